// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, response and memory-side signals of the port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [1:0]              req_we;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic                    mem_sel;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, mem_ready, mem_rsp_valid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_sel, mem_valid, mem_addr, mem_we,
           mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata, mem_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_sel, mem_valid, mem_addr, mem_we,
           mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  grant;
  logic [1:0]            req_ready_c;

  always_comb begin
    grant        = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    req_ready_c  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c = grant ? 2'b10 : 2'b01;
          sel_d       = grant;
          addr_d      = grant ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.req_addr[ADDR_WIDTH-1:0];
          we_d        = grant ? bus.req_we[1] : bus.req_we[0];
          wdata_d     = grant ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_wdata[DATA_WIDTH-1:0];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.mem_ready) begin
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A real response beats a timeout landing in the same cycle.
        if (bus.mem_rsp_valid || cnt_q == 8'(TIMEOUT - 1)) begin
          rsp_valid_d  = sel_q ? 2'b10 : 2'b01;
          rsp_rdata_d  = bus.mem_rsp_valid ? bus.mem_rdata : '0;
          rsp_err_d    = ~bus.mem_rsp_valid;
          last_grant_d = sel_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 8'd0;
      sel_q        <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Grant is suppressed while reset is held so nothing is accepted that reset will discard.
  assign bus.req_ready = reset ? 2'b00 : req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_valid = (state_q == S_ISSUE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
endmodule
